// File: rtl/ysyx_23060191_idex_pkg.sv
// Shared widths, operand-select encodings, state encoding and entry layout
// for the ID/EX issue stage.
package ysyx_23060191_idex_pkg;

    localparam int CPU_WIDTH      = 32;
    localparam int ALU_OPT_WIDTH  = 5;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [1:0] SRC1_RS1  = 2'b00;
    localparam logic [1:0] SRC1_PC   = 2'b01;
    localparam logic [1:0] SRC1_ZERO = 2'b10;

    localparam logic [1:0] SRC2_RS2  = 2'b00;
    localparam logic [1:0] SRC2_IMM  = 2'b01;
    localparam logic [1:0] SRC2_FOUR = 2'b10;
    localparam logic [1:0] SRC2_ZERO = 2'b11;

    // Encoded directly as {main_v, skid_v}.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } idex_state_e;

    // One held instruction: operands are stored already selected.
    typedef struct packed {
        logic [CPU_WIDTH-1:0]      alu_in1;
        logic [CPU_WIDTH-1:0]      alu_in2;
        logic [ALU_OPT_WIDTH-1:0]  alu_opt;
        logic [CPU_WIDTH-1:0]      pc;
        logic [CPU_WIDTH-1:0]      rs2_data;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic                      rd_wen;
    } idex_entry_t;

endpackage

// File: rtl/ysyx_23060191_idex_opsel.sv
// Combinational ALU operand multiplexer; its outputs are registered by the
// issue stage so the ALU never sees this mux on its input path.
module ysyx_23060191_idex_opsel
    import ysyx_23060191_idex_pkg::*;
(
    input  logic [CPU_WIDTH-1:0] i_pc,
    input  logic [CPU_WIDTH-1:0] i_rs1_data,
    input  logic [CPU_WIDTH-1:0] i_rs2_data,
    input  logic [CPU_WIDTH-1:0] i_imm,
    input  logic [1:0]           i_src1_sel,
    input  logic [1:0]           i_src2_sel,
    output logic [CPU_WIDTH-1:0] o_op1,
    output logic [CPU_WIDTH-1:0] o_op2
);

    // Operand 1: rs1, pc, or zero for both remaining codes.
    always_comb begin
        o_op1 = '0;
        case (i_src1_sel)
            SRC1_RS1:  o_op1 = i_rs1_data;
            SRC1_PC:   o_op1 = i_pc;
            SRC1_ZERO: o_op1 = '0;
            default:   o_op1 = '0;
        endcase
    end

    // Operand 2: rs2, immediate, zero-extended 4 (link address), or zero.
    always_comb begin
        o_op2 = '0;
        case (i_src2_sel)
            SRC2_RS2:  o_op2 = i_rs2_data;
            SRC2_IMM:  o_op2 = i_imm;
            SRC2_FOUR: o_op2 = CPU_WIDTH'(4);
            SRC2_ZERO: o_op2 = '0;
            default:   o_op2 = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_23060191_idex.sv
// ID/EX issue stage: two-entry skid buffer between the IDU and the ALU.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | nothing held, o_ex_valid low
// ST_ONE   | main holds the head entry, skid free
// ST_FULL  | main holds the head, skid holds the next entry, not ready
module ysyx_23060191_idex
    import ysyx_23060191_idex_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_flush,
    input  logic                      i_id_valid,
    output logic                      o_id_ready,
    input  logic [CPU_WIDTH-1:0]      i_id_pc,
    input  logic [CPU_WIDTH-1:0]      i_id_rs1_data,
    input  logic [CPU_WIDTH-1:0]      i_id_rs2_data,
    input  logic [CPU_WIDTH-1:0]      i_id_imm,
    input  logic [1:0]                i_id_src1_sel,
    input  logic [1:0]                i_id_src2_sel,
    input  logic [ALU_OPT_WIDTH-1:0]  i_id_alu_opt_code,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rd_addr,
    input  logic                      i_id_rd_wen,
    output logic                      o_ex_valid,
    input  logic                      i_ex_ready,
    output logic [CPU_WIDTH-1:0]      o_alu_in1,
    output logic [CPU_WIDTH-1:0]      o_alu_in2,
    output logic [ALU_OPT_WIDTH-1:0]  o_alu_opt_code,
    output logic [CPU_WIDTH-1:0]      o_ex_pc,
    output logic [CPU_WIDTH-1:0]      o_ex_rs2_data,
    output logic [REG_ADDR_WIDTH-1:0] o_ex_rd_addr,
    output logic                      o_ex_rd_wen
);

    logic [CPU_WIDTH-1:0] sel_op1;
    logic [CPU_WIDTH-1:0] sel_op2;
    idex_entry_t          in_entry;

    idex_state_e state_q, state_d;
    logic        ready_q, ready_d;
    idex_entry_t main_q, main_d;
    idex_entry_t skid_q, skid_d;

    logic main_v;
    logic accept;
    logic consume;

    ysyx_23060191_idex_opsel u_opsel (
        .i_pc       (i_id_pc),
        .i_rs1_data (i_id_rs1_data),
        .i_rs2_data (i_id_rs2_data),
        .i_imm      (i_id_imm),
        .i_src1_sel (i_id_src1_sel),
        .i_src2_sel (i_id_src2_sel),
        .o_op1      (sel_op1),
        .o_op2      (sel_op2)
    );

    // Pack the incoming instruction with its already-selected operands.
    always_comb begin
        in_entry          = '0;
        in_entry.alu_in1  = sel_op1;
        in_entry.alu_in2  = sel_op2;
        in_entry.alu_opt  = i_id_alu_opt_code;
        in_entry.pc       = i_id_pc;
        in_entry.rs2_data = i_id_rs2_data;
        in_entry.rd_addr  = i_id_rd_addr;
        in_entry.rd_wen   = i_id_rd_wen;
    end

    assign main_v  = (state_q != ST_EMPTY);
    assign accept  = i_id_valid && ready_q;
    assign consume = main_v && i_ex_ready;

    // Next state and entry data; data only moves on accept or skid-to-main.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_entry;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_d = in_entry;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_d  = in_entry;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        // Ready is registered so it never depends combinationally on i_ex_ready.
        ready_d = (state_d != ST_FULL);
    end

    // Single register block for state, ready and both entries.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign o_id_ready     = ready_q;
    assign o_ex_valid     = main_v;
    assign o_alu_in1      = main_q.alu_in1;
    assign o_alu_in2      = main_q.alu_in2;
    assign o_alu_opt_code = main_q.alu_opt;
    assign o_ex_pc        = main_q.pc;
    assign o_ex_rs2_data  = main_q.rs2_data;
    assign o_ex_rd_addr   = main_q.rd_addr;
    assign o_ex_rd_wen    = main_q.rd_wen && main_v;

endmodule

// File: tb/tb_ysyx_23060191_idex.sv
// Bench for the ID/EX skid-buffer stage: table-driven operand vectors plus
// hand-written stall/flush/simultaneous sequences and a random soak, all
// checked against a queue scoreboard of expected head entries.
module tb_ysyx_23060191_idex;
    import ysyx_23060191_idex_pkg::*;

    logic        clk = 1'b0;
    logic        i_rst, i_flush, i_id_valid, i_ex_ready;
    logic [31:0] i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm;
    logic [1:0]  i_id_src1_sel, i_id_src2_sel;
    logic [4:0]  i_id_alu_opt_code, i_id_rd_addr;
    logic        i_id_rd_wen;
    logic        o_id_ready, o_ex_valid, o_ex_rd_wen;
    logic [31:0] o_alu_in1, o_alu_in2, o_ex_pc, o_ex_rs2_data;
    logic [4:0]  o_alu_opt_code, o_ex_rd_addr;

    always #5 clk = ~clk;

    ysyx_23060191_idex dut (
        .i_clk             (clk),
        .i_rst             (i_rst),
        .i_flush           (i_flush),
        .i_id_valid        (i_id_valid),
        .o_id_ready        (o_id_ready),
        .i_id_pc           (i_id_pc),
        .i_id_rs1_data     (i_id_rs1_data),
        .i_id_rs2_data     (i_id_rs2_data),
        .i_id_imm          (i_id_imm),
        .i_id_src1_sel     (i_id_src1_sel),
        .i_id_src2_sel     (i_id_src2_sel),
        .i_id_alu_opt_code (i_id_alu_opt_code),
        .i_id_rd_addr      (i_id_rd_addr),
        .i_id_rd_wen       (i_id_rd_wen),
        .o_ex_valid        (o_ex_valid),
        .i_ex_ready        (i_ex_ready),
        .o_alu_in1         (o_alu_in1),
        .o_alu_in2         (o_alu_in2),
        .o_alu_opt_code    (o_alu_opt_code),
        .o_ex_pc           (o_ex_pc),
        .o_ex_rs2_data     (o_ex_rs2_data),
        .o_ex_rd_addr      (o_ex_rd_addr),
        .o_ex_rd_wen       (o_ex_rd_wen)
    );

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm;
        logic [1:0]  s1, s2;
        logic [4:0]  opt, rd;
        logic        wen;
        logic [31:0] exp1, exp2;
    } vec_t;

    typedef struct {
        logic [31:0] in1, in2;
        logic [4:0]  opt;
        logic [31:0] pc, rs2;
        logic [4:0]  rd;
        logic        wen;
    } exp_t;

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string phase = "init";
    vec_t  tbl[8];
    vec_t  idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s/%s: got 0x%08h expected 0x%08h", phase, name, act, req);
        end
    endtask

    // Independent operand-select model for hand-built and random entries.
    function automatic vec_t mk(input logic [31:0] pc, rs1, rs2, imm, input logic [1:0] s1, s2,
                                input logic [4:0] opt, rd, input logic wen);
        vec_t v;
        v = '{pc, rs1, rs2, imm, s1, s2, opt, rd, wen, 32'h0, 32'h0};
        case (s1)
            2'b00:   v.exp1 = rs1;
            2'b01:   v.exp1 = pc;
            default: v.exp1 = 32'h0;
        endcase
        case (s2)
            2'b00:   v.exp2 = rs2;
            2'b01:   v.exp2 = imm;
            2'b10:   v.exp2 = 32'd4;
            default: v.exp2 = 32'h0;
        endcase
        return v;
    endfunction

    task automatic check_outputs();
        chk("ex_valid", 32'(o_ex_valid), 32'(sb.size() > 0));
        chk("id_ready", 32'(o_id_ready), 32'(sb.size() < 2));
        if (sb.size() > 0) begin
            chk("alu_in1", o_alu_in1, sb[0].in1);
            chk("alu_in2", o_alu_in2, sb[0].in2);
            chk("alu_opt", 32'(o_alu_opt_code), 32'(sb[0].opt));
            chk("ex_pc", o_ex_pc, sb[0].pc);
            chk("rs2_data", o_ex_rs2_data, sb[0].rs2);
            chk("rd_addr", 32'(o_ex_rd_addr), 32'(sb[0].rd));
            chk("rd_wen", 32'(o_ex_rd_wen), 32'(sb[0].wen));
        end else begin
            chk("rd_wen_idle", 32'(o_ex_rd_wen), 32'h0);
        end
    endtask

    task automatic drive(input logic valid, input vec_t v, input logic exr, input logic fl);
        i_id_valid        = valid;
        i_id_pc           = v.pc;
        i_id_rs1_data     = v.rs1;
        i_id_rs2_data     = v.rs2;
        i_id_imm          = v.imm;
        i_id_src1_sel     = v.s1;
        i_id_src2_sel     = v.s2;
        i_id_alu_opt_code = v.opt;
        i_id_rd_addr      = v.rd;
        i_id_rd_wen       = v.wen;
        i_ex_ready        = exr;
        i_flush           = fl;
    endtask

    // One clock: push the expected entry on accept, pop on consume, then check.
    task automatic step(input logic valid, input vec_t v, input logic exr, input logic fl);
        bit   acc, con;
        exp_t e;
        drive(valid, v, exr, fl);
        acc = valid && (sb.size() < 2);
        con = (sb.size() > 0) && exr;
        e   = '{v.exp1, v.exp2, v.opt, v.pc, v.rs2, v.rd, v.wen};
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            if (con) void'(sb.pop_front());
            if (acc) sb.push_back(e);
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int cycles);
        i_rst = 1'b1;
        drive(1'b1, tbl[2], 1'b0, 1'b0);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
        sb.delete();
        chk("rst_ex_valid", 32'(o_ex_valid), 32'h0);
        chk("rst_id_ready", 32'(o_id_ready), 32'h1);
        chk("rst_alu_in1", o_alu_in1, 32'h0);
        chk("rst_alu_in2", o_alu_in2, 32'h0);
        chk("rst_alu_opt", 32'(o_alu_opt_code), 32'h0);
        chk("rst_ex_pc", o_ex_pc, 32'h0);
        chk("rst_rs2", o_ex_rs2_data, 32'h0);
        chk("rst_rd_addr", 32'(o_ex_rd_addr), 32'h0);
        chk("rst_rd_wen", 32'(o_ex_rd_wen), 32'h0);
        i_rst = 1'b0;
        drive(1'b0, idle, 1'b0, 1'b0);
    endtask

    initial begin
        vec_t a, b, c, d, r;
        idle   = mk(32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 5'd0, 5'd0, 1'b0);
        // pc, rs1, rs2, imm, s1, s2, opt, rd, wen, expected in1, expected in2
        tbl[0] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'b01, 2'b10, 5'd1,  5'd1,  1'b1, 32'h8000_0000, 32'h0000_0004};
        tbl[1] = '{32'h8000_0004, 32'h0000_0005, 32'h0000_0009, 32'hFFFF_FFFF, 2'b00, 2'b01, 5'd2,  5'd2,  1'b0, 32'h0000_0005, 32'hFFFF_FFFF};
        tbl[2] = '{32'h8000_0008, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0010, 2'b00, 2'b00, 5'd3,  5'd3,  1'b1, 32'h1234_5678, 32'h9ABC_DEF0};
        tbl[3] = '{32'h8000_000C, 32'hAAAA_5555, 32'h0000_0011, 32'h0000_0022, 2'b10, 2'b11, 5'd4,  5'd31, 1'b1, 32'h0000_0000, 32'h0000_0000};
        tbl[4] = '{32'h0000_0100, 32'h0000_0077, 32'h0000_0088, 32'h0000_0099, 2'b11, 2'b10, 5'd5,  5'd5,  1'b0, 32'h0000_0000, 32'h0000_0004};
        tbl[5] = '{32'h8000_0010, 32'h0000_0001, 32'h0000_0002, 32'h0000_0800, 2'b01, 2'b01, 5'd6,  5'd6,  1'b1, 32'h8000_0010, 32'h0000_0800};
        tbl[6] = '{32'h8000_0014, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0003, 2'b00, 2'b11, 5'd7,  5'd7,  1'b0, 32'hDEAD_BEEF, 32'h0000_0000};
        tbl[7] = '{32'h8000_0020, 32'h0000_0000, 32'hCAFE_F00D, 32'h0000_0000, 2'b01, 2'b00, 5'd31, 5'd15, 1'b1, 32'h8000_0020, 32'hCAFE_F00D};

        phase = "reset";
        do_reset(2);

        phase = "stream";
        for (int i = 0; i < 8; i++) step(1'b1, tbl[i], 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);

        phase = "stall";
        a = mk(32'h8000_0100, 32'hA000_0001, 32'hA000_0002, 32'h0, 2'b00, 2'b00, 5'd8, 5'd10, 1'b1);
        b = mk(32'h8000_0104, 32'hB000_0001, 32'hB000_0002, 32'h40, 2'b01, 2'b01, 5'd9, 5'd11, 1'b1);
        c = mk(32'h8000_0108, 32'hC000_0001, 32'hC000_0002, 32'h0, 2'b00, 2'b10, 5'd10, 5'd12, 1'b1);
        d = mk(32'h8000_010C, 32'hD000_0001, 32'hD000_0002, 32'h7, 2'b10, 2'b01, 5'd11, 5'd13, 1'b0);
        step(1'b1, a, 1'b0, 1'b0);
        step(1'b1, b, 1'b0, 1'b0);
        step(1'b1, c, 1'b0, 1'b0);
        step(1'b0, idle, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);

        phase = "flush_full";
        step(1'b1, a, 1'b0, 1'b0);
        step(1'b1, b, 1'b0, 1'b0);
        step(1'b1, c, 1'b0, 1'b1);
        step(1'b0, idle, 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);

        phase = "flush_one";
        step(1'b1, a, 1'b0, 1'b0);
        step(1'b1, c, 1'b1, 1'b1);
        step(1'b0, idle, 1'b1, 1'b0);

        phase = "simul";
        step(1'b1, a, 1'b0, 1'b0);
        step(1'b1, d, 1'b1, 1'b0);
        step(1'b0, idle, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            r = mk($urandom, $urandom, $urandom, $urandom, 2'($urandom), 2'($urandom),
                   5'($urandom), 5'($urandom), 1'($urandom));
            step(($urandom % 4) != 0, r, ($urandom % 3) != 0, ($urandom % 25) == 0);
        end

        phase = "mid_reset";
        step(1'b1, a, 1'b0, 1'b0);
        step(1'b1, b, 1'b0, 1'b0);
        do_reset(1);
        step(1'b0, idle, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
